// File: rtl/pic_pkg.sv
// Shared definitions for the parameterised interrupt controller.
// Contents: register addresses, CTRL/EOI/STATUS bit positions,
// the handshake FSM state type and a helper that maps a priority
// rank onto a channel index for a given lowest-priority pointer.
package pic_pkg;

    localparam int ID_W = 5;  // channel ids fit 5 bits for up to 32 channels

    localparam logic [2:0] ADDR_MASK   = 3'd0;
    localparam logic [2:0] ADDR_TRIG   = 3'd1;
    localparam logic [2:0] ADDR_CTRL   = 3'd2;
    localparam logic [2:0] ADDR_EOI    = 3'd3;
    localparam logic [2:0] ADDR_IRR    = 3'd4;
    localparam logic [2:0] ADDR_ISR    = 3'd5;
    localparam logic [2:0] ADDR_STATUS = 3'd6;

    localparam int CTRL_AEOI_BIT   = 0;
    localparam int CTRL_ROTATE_BIT = 1;
    localparam int CTRL_VEC_LSB    = 8;

    localparam int EOI_SPECIFIC_BIT = 8;
    localparam int EOI_ID_LSB       = 0;

    localparam int STATUS_INT_BIT  = 0;
    localparam int STATUS_ID_LSB   = 8;
    localparam int STATUS_BUSY_BIT = 15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ACK2 = 2'd2
    } pic_state_t;

    // Channel that holds priority rank k (0 = highest) when lp is the
    // lowest-priority channel. lp < n and k < n, so one wrap suffices.
    function automatic logic [ID_W-1:0] prio_idx(input logic [ID_W-1:0] lp,
                                                 input int k, input int n);
        int t;
        t = int'(lp) + 1 + k;
        if (t >= n) t = t - n;
        return t[ID_W-1:0];
    endfunction

endpackage

// File: rtl/param_pic_if.sv
// CPU-side bus of the interrupt controller.
// Signals: irq request lines, register strobes/address/data, inta
// acknowledge pulse, int_o request to CPU, vec/vec_valid vector output.
// master = CPU/stimulus side, slave = controller side.
interface param_pic_if #(
    parameter int NUM_IRQ = 8,
    parameter int VEC_W   = 8
);
    logic [NUM_IRQ-1:0] irq;
    logic               wr_en;
    logic               rd_en;
    logic [2:0]         addr;
    logic [31:0]        wdata;
    logic [31:0]        rdata;
    logic               inta;
    logic               int_o;
    logic [VEC_W-1:0]   vec;
    logic               vec_valid;

    modport master (
        output irq, wr_en, rd_en, addr, wdata, inta,
        input  rdata, int_o, vec, vec_valid
    );

    modport slave (
        input  irq, wr_en, rd_en, addr, wdata, inta,
        output rdata, int_o, vec, vec_valid
    );
endinterface

// File: rtl/pic_prio_resolver.sv
// Combinational rotating-priority resolver.
// Inputs : req (unmasked IRR), isr (in-service bits), lp (lowest-priority id)
// Outputs: valid (eligible candidate exists), id (highest-priority request),
//          isr_valid/isr_id (highest-priority in-service channel)
module pic_prio_resolver
    import pic_pkg::*;
#(
    parameter int NUM_IRQ = 8
) (
    input  logic [NUM_IRQ-1:0] req,
    input  logic [NUM_IRQ-1:0] isr,
    input  logic [ID_W-1:0]    lp,
    output logic               valid,
    output logic [ID_W-1:0]    id,
    output logic               isr_valid,
    output logic [ID_W-1:0]    isr_id
);
    logic [31:0]     req_ext;
    logic [31:0]     isr_ext;
    logic [ID_W-1:0] order [NUM_IRQ];
    logic            found;

    assign req_ext = 32'(req);
    assign isr_ext = 32'(isr);

    generate
        for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_order
            assign order[gi] = prio_idx(lp, gi, NUM_IRQ);
        end
    endgenerate

    // Walk ranks from highest to lowest. The ISR test comes first so that a
    // request on a channel already in service is not "strictly above" it.
    always_comb begin
        valid     = 1'b0;
        id        = '0;
        isr_valid = 1'b0;
        isr_id    = '0;
        found     = 1'b0;
        for (int k = 0; k < NUM_IRQ; k++) begin
            if (!isr_valid && isr_ext[order[k]]) begin
                isr_valid = 1'b1;
                isr_id    = order[k];
            end
            if (!found && req_ext[order[k]]) begin
                found = 1'b1;
                id    = order[k];
                valid = !isr_valid;
            end
        end
    end
endmodule

// File: rtl/param_pic.sv
// Parameterised programmable interrupt controller (fully nested,
// optional rotation and auto-EOI, two-pulse acknowledge).
// Ports: clk, reset (sync, active high), bus (param_pic_if.slave) carrying
// irq, register access, inta, int_o and vec/vec_valid.
module param_pic
    import pic_pkg::*;
#(
    parameter int NUM_IRQ = 8,
    parameter int VEC_W   = 8
) (
    input logic        clk,
    input logic        reset,
    param_pic_if.slave bus
);
    logic [NUM_IRQ-1:0] mask_reg, trig_reg, irr_reg, isr_reg, irq_prev_reg;
    logic [NUM_IRQ-1:0] irr_next, isr_next, req_vec;
    logic [NUM_IRQ-1:0] ack_hot, eoi_hot, aeoi_hot;
    logic               aeoi_reg, rotate_reg;
    logic [VEC_W-1:0]   vec_base_reg, vec_reg, vec_sum;
    logic               vec_valid_reg;
    logic [ID_W-1:0]    lp_reg, id_reg;
    pic_state_t         state_reg, state_next;

    logic               cand_valid, isr_any;
    logic [ID_W-1:0]    cand_id, top_isr_id, eoi_idx;
    logic               ack, deliver, spurious, eoi_clr, aeoi_clr;
    logic [31:0]        rd_data;

    assign req_vec = irr_reg & ~mask_reg;

    pic_prio_resolver #(.NUM_IRQ(NUM_IRQ)) u_prio (
        .req       (req_vec),
        .isr       (isr_reg),
        .lp        (lp_reg),
        .valid     (cand_valid),
        .id        (cand_id),
        .isr_valid (isr_any),
        .isr_id    (top_isr_id)
    );

    // EOI decode: out-of-range specific ids and an empty ISR are no-ops.
    always_comb begin
        eoi_clr = 1'b0;
        eoi_idx = '0;
        if (bus.wr_en && (bus.addr == ADDR_EOI) && isr_any) begin
            if (bus.wdata[EOI_SPECIFIC_BIT]) begin
                if (int'(bus.wdata[EOI_ID_LSB +: ID_W]) < NUM_IRQ) begin
                    eoi_clr = 1'b1;
                    eoi_idx = bus.wdata[EOI_ID_LSB +: ID_W];
                end
            end else begin
                eoi_clr = 1'b1;
                eoi_idx = top_isr_id;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        ack        = 1'b0;
        deliver    = 1'b0;
        spurious   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (bus.inta) spurious = 1'b1;
                if (cand_valid) state_next = ST_REQ;
            end
            ST_REQ: begin
                if (bus.inta && cand_valid) begin
                    ack        = 1'b1;
                    state_next = ST_ACK2;
                end else if (!cand_valid) begin
                    state_next = ST_IDLE;
                end
            end
            ST_ACK2: begin
                if (bus.inta) begin
                    deliver    = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign aeoi_clr = deliver && aeoi_reg;

    generate
        for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_hot
            assign ack_hot[gi]  = ack && (cand_id == ID_W'(gi));
            assign eoi_hot[gi]  = eoi_clr && (eoi_idx == ID_W'(gi));
            assign aeoi_hot[gi] = aeoi_clr && (id_reg == ID_W'(gi));
        end
    endgenerate

    // Set terms are OR-ed last so ack beats EOI on ISR and a fresh edge
    // beats the ack clear on IRR.
    assign isr_next = (isr_reg & ~eoi_hot & ~aeoi_hot) | ack_hot;
    assign irr_next = (trig_reg & ((irr_reg & ~ack_hot) | (bus.irq & ~irq_prev_reg)))
                    | (~trig_reg & bus.irq);

    assign vec_sum = vec_base_reg + (deliver ? VEC_W'(id_reg) : VEC_W'(NUM_IRQ - 1));

    always_ff @(posedge clk) begin
        if (reset) state_reg <= ST_IDLE;
        else       state_reg <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mask_reg      <= '1;
            trig_reg      <= '1;
            aeoi_reg      <= 1'b0;
            rotate_reg    <= 1'b0;
            vec_base_reg  <= '0;
            irr_reg       <= '0;
            isr_reg       <= '0;
            irq_prev_reg  <= '0;
            lp_reg        <= ID_W'(NUM_IRQ - 1);
            id_reg        <= '0;
            vec_reg       <= '0;
            vec_valid_reg <= 1'b0;
        end else begin
            irr_reg       <= irr_next;
            isr_reg       <= isr_next;
            irq_prev_reg  <= bus.irq;
            vec_valid_reg <= deliver || spurious;
            if (deliver || spurious) vec_reg <= vec_sum;
            if (ack) id_reg <= cand_id;
            if (rotate_reg && aeoi_clr)     lp_reg <= id_reg;
            else if (rotate_reg && eoi_clr) lp_reg <= eoi_idx;
            if (bus.wr_en) begin
                case (bus.addr)
                    ADDR_MASK: mask_reg <= bus.wdata[NUM_IRQ-1:0];
                    ADDR_TRIG: trig_reg <= bus.wdata[NUM_IRQ-1:0];
                    ADDR_CTRL: begin
                        aeoi_reg     <= bus.wdata[CTRL_AEOI_BIT];
                        rotate_reg   <= bus.wdata[CTRL_ROTATE_BIT];
                        vec_base_reg <= bus.wdata[CTRL_VEC_LSB +: VEC_W];
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rd_data = '0;
        if (bus.rd_en) begin
            case (bus.addr)
                ADDR_MASK: rd_data = 32'(mask_reg);
                ADDR_TRIG: rd_data = 32'(trig_reg);
                ADDR_CTRL: begin
                    rd_data[CTRL_AEOI_BIT]           = aeoi_reg;
                    rd_data[CTRL_ROTATE_BIT]         = rotate_reg;
                    rd_data[CTRL_VEC_LSB +: VEC_W]   = vec_base_reg;
                end
                ADDR_IRR: rd_data = 32'(irr_reg);
                ADDR_ISR: rd_data = 32'(isr_reg);
                ADDR_STATUS: begin
                    rd_data[STATUS_INT_BIT]        = (state_reg == ST_REQ);
                    rd_data[STATUS_ID_LSB +: ID_W] = cand_id;
                    rd_data[STATUS_BUSY_BIT]       = (state_reg != ST_IDLE);
                end
                default: rd_data = '0;
            endcase
        end
    end

    assign bus.rdata     = rd_data;
    assign bus.int_o     = (state_reg == ST_REQ);
    assign bus.vec       = vec_reg;
    assign bus.vec_valid = vec_valid_reg;
endmodule

// File: tb/tb_param_pic.sv
`timescale 1ns/1ps
module tb_param_pic;
    localparam int N   = 8;
    localparam int N32 = 32;
    localparam int VW  = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    param_pic_if #(.NUM_IRQ(N),   .VEC_W(VW)) b8  ();
    param_pic_if #(.NUM_IRQ(N32), .VEC_W(VW)) b32 ();

    param_pic #(.NUM_IRQ(N),   .VEC_W(VW)) dut8  (.clk(clk), .reset(reset), .bus(b8));
    param_pic #(.NUM_IRQ(N32), .VEC_W(VW)) dut32 (.clk(clk), .reset(reset), .bus(b32));

    int tests_run    = 0;
    int tests_failed = 0;
    logic [31:0] last_rd;

    // ---------------- behavioural reference model (8 channels) -------------
    bit [N-1:0]  m_mask, m_trig, m_irr, m_isr, m_prev;
    bit          m_aeoi, m_rot, m_vv;
    bit [VW-1:0] m_base, m_vec;
    int          m_lp, m_phase, m_id;   // phase: 0 idle, 1 requesting, 2 awaiting 2nd inta

    function automatic int rank(input int i);
        return (i - m_lp - 1 + 2 * N) % N;
    endfunction

    function automatic int best_of(input bit [N-1:0] v);
        int b;
        b = -1;
        for (int i = 0; i < N; i++)
            if (v[i] && (b < 0 || rank(i) < rank(b))) b = i;
        return b;
    endfunction

    function automatic bit m_eligible();
        int c, t;
        c = best_of(m_irr & ~m_mask);
        t = best_of(m_isr);
        return (c >= 0) && (t < 0 || rank(c) < rank(t));
    endfunction

    function automatic logic [31:0] m_read(input logic [2:0] a);
        int c;
        c = best_of(m_irr & ~m_mask);
        if (c < 0) c = 0;
        case (a)
            3'd0: return 32'(m_mask);
            3'd1: return 32'(m_trig);
            3'd2: return (32'(m_base) << 8) | (32'(m_rot) << 1) | 32'(m_aeoi);
            3'd4: return 32'(m_irr);
            3'd5: return 32'(m_isr);
            3'd6: return (32'(m_phase != 0) << 15) | (32'(c) << 8) | 32'(m_phase == 1);
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_mask = '1; m_trig = '1; m_irr = '0; m_isr = '0; m_prev = '0;
        m_aeoi = 0; m_rot = 0; m_base = '0; m_vec = '0; m_vv = 0;
        m_lp = N - 1; m_phase = 0; m_id = 0;
    endtask

    task automatic model_step(input bit [N-1:0] irq_v, input bit inta_v, input bit wr_v,
                              input logic [2:0] a, input logic [31:0] wd);
        int c, t, idx;
        bit elig, ack;
        bit [N-1:0] n_irr, n_isr;
        int n_lp;
        c = best_of(m_irr & ~m_mask);
        t = best_of(m_isr);
        elig = m_eligible();
        n_isr = m_isr; n_lp = m_lp; m_vv = 0; ack = 0;
        if (wr_v && a == 3'd3 && m_isr != 0) begin
            idx = wd[8] ? int'(wd[4:0]) : t;
            if (idx < N) begin
                n_isr[idx] = 0;
                if (m_rot) n_lp = idx;
            end
        end
        case (m_phase)
            0: begin
                if (inta_v) begin m_vv = 1; m_vec = m_base + VW'(N - 1); end
                if (elig) m_phase = 1;
            end
            1: begin
                if (inta_v && elig) begin ack = 1; m_id = c; m_phase = 2; end
                else if (!elig) m_phase = 0;
            end
            default: begin
                if (inta_v) begin
                    m_vv = 1; m_vec = m_base + VW'(m_id);
                    if (m_aeoi) begin n_isr[m_id] = 0; if (m_rot) n_lp = m_id; end
                    m_phase = 0;
                end
            end
        endcase
        if (ack) n_isr[c] = 1;
        for (int i = 0; i < N; i++) begin
            if (m_trig[i]) n_irr[i] = (m_irr[i] && !(ack && i == c)) || (irq_v[i] && !m_prev[i]);
            else           n_irr[i] = irq_v[i];
        end
        if (wr_v) begin
            case (a)
                3'd0: m_mask = wd[N-1:0];
                3'd1: m_trig = wd[N-1:0];
                3'd2: begin m_aeoi = wd[0]; m_rot = wd[1]; m_base = wd[8 +: VW]; end
                default: ;
            endcase
        end
        m_irr = n_irr; m_isr = n_isr; m_lp = n_lp; m_prev = irq_v;
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock of the 8-channel DUT: drive, check read data, step model,
    // clock, check outputs. Called at #1 after a rising edge.
    task automatic cyc(input logic [N-1:0] irq_v, input logic inta_v, input logic wr_v,
                       input logic [2:0] a, input logic [31:0] wd);
        b8.irq = irq_v; b8.inta = inta_v; b8.wr_en = wr_v; b8.rd_en = 1'b1;
        b8.addr = a; b8.wdata = wd;
        #1;
        last_rd = b8.rdata;
        check("rdata", last_rd, m_read(a));
        model_step(irq_v, inta_v, wr_v, a, wd);
        @(posedge clk); #1;
        check("int_o", 32'(b8.int_o), 32'(m_phase == 1));
        check("vec_valid", 32'(b8.vec_valid), 32'(m_vv));
        check("vec", 32'(b8.vec), 32'(m_vec));
        if (m_vv) $display("[TB] t=%0t vector 0x%0h delivered", $time, b8.vec);
    endtask

    task automatic c32(input logic [N32-1:0] irq_v, input logic inta_v, input logic wr_v,
                       input logic [2:0] a, input logic [31:0] wd);
        b32.irq = irq_v; b32.inta = inta_v; b32.wr_en = wr_v; b32.rd_en = 1'b1;
        b32.addr = a; b32.wdata = wd;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        b8.irq = '0; b8.inta = 0; b8.wr_en = 0; b8.rd_en = 0; b8.addr = '0; b8.wdata = '0;
        b32.irq = '0; b32.inta = 0; b32.wr_en = 0; b32.rd_en = 0; b32.addr = '0; b32.wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        check("reset_int_o", 32'(b8.int_o), 32'd0);
        check("reset_vec_valid", 32'(b8.vec_valid), 32'd0);
        check("reset_vec", 32'(b8.vec), 32'd0);
    endtask

    task automatic setup(input logic [31:0] ctrl);
        do_reset();
        cyc('0, 0, 1, 3'd0, 32'h0);
        cyc('0, 0, 1, 3'd2, ctrl);
    endtask

    task automatic wait_int(input logic [N-1:0] irq_v, input string tag);
        int n;
        n = 0;
        while (!b8.int_o && n < 10) begin
            cyc(irq_v, 0, 0, 3'd6, 32'h0);
            n++;
        end
        check(tag, 32'(b8.int_o), 32'd1);
    endtask

    task automatic serve(input logic [VW-1:0] exp_vec, input string tag);
        cyc('0, 1, 0, 3'd5, 32'h0);
        cyc('0, 1, 0, 3'd5, 32'h0);
        check({tag, "_valid"}, 32'(b8.vec_valid), 32'd1);
        check({tag, "_vec"}, 32'(b8.vec), 32'(exp_vec));
        $display("[TB] %s: served vector 0x%0h", tag, b8.vec);
    endtask

    typedef struct {
        logic        wr;
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } reg_vec_t;

    reg_vec_t tbl [13];

    initial begin
        logic [N-1:0] irq_v;
        logic         inta_v, wr_v;
        logic [2:0]   a;
        logic [31:0]  wd;
        int           r;

        tbl[0]  = '{0, 3'd0, 32'h0,        32'h0000_00FF};
        tbl[1]  = '{0, 3'd1, 32'h0,        32'h0000_00FF};
        tbl[2]  = '{0, 3'd2, 32'h0,        32'h0};
        tbl[3]  = '{0, 3'd4, 32'h0,        32'h0};
        tbl[4]  = '{0, 3'd5, 32'h0,        32'h0};
        tbl[5]  = '{0, 3'd6, 32'h0,        32'h0};
        tbl[6]  = '{0, 3'd7, 32'h0,        32'h0};
        tbl[7]  = '{1, 3'd0, 32'hFFFF_FF5A, 32'h0000_005A};
        tbl[8]  = '{1, 3'd1, 32'h0000_01F0, 32'h0000_00F0};
        tbl[9]  = '{1, 3'd2, 32'hFFFF_FFFF, 32'h0000_FF03};
        tbl[10] = '{1, 3'd7, 32'hFFFF_FFFF, 32'h0};
        tbl[11] = '{0, 3'd3, 32'h0,        32'h0};
        tbl[12] = '{1, 3'd2, 32'h0000_2000, 32'h0000_2000};

        // Register map, reset values and read masking
        do_reset();
        for (int i = 0; i < 13; i++) begin
            if (tbl[i].wr) cyc('0, 0, 1, tbl[i].addr, tbl[i].wdata);
            cyc('0, 0, 0, tbl[i].addr, 32'h0);
            check("table", last_rd, tbl[i].exp);
            $display("[TB] reg vector %0d addr=%0d rdata=0x%0h", i, tbl[i].addr, last_rd);
        end
        b8.rd_en = 0; b8.addr = 3'd0; #1;
        check("rd_en_low", b8.rdata, 32'h0);
        @(posedge clk); #1;

        // Edge on channel 3, full two-pulse acknowledge
        setup(32'h0000_2000);
        cyc(8'h08, 0, 0, 3'd6, 32'h0);
        cyc(8'h00, 0, 0, 3'd6, 32'h0);
        check("edge3_int", 32'(b8.int_o), 32'd1);
        cyc('0, 1, 0, 3'd6, 32'h0);
        check("edge3_int_drop", 32'(b8.int_o), 32'd0);
        cyc('0, 1, 0, 3'd6, 32'h0);
        check("edge3_vec", 32'(b8.vec), 32'h23);
        cyc('0, 0, 0, 3'd5, 32'h0);
        check("edge3_isr", last_rd, 32'h08);
        cyc('0, 0, 0, 3'd4, 32'h0);
        check("edge3_irr", last_rd, 32'h00);
        $display("[TB] edge channel 3 sequence done");

        // Nesting: channel 2 in service blocks channel 5 until EOI
        setup(32'h0000_2000);
        cyc(8'h04, 0, 0, 3'd6, 32'h0);
        wait_int('0, "nest_int2");
        serve(8'h22, "nest_ch2");
        cyc(8'h20, 0, 0, 3'd6, 32'h0);
        for (int i = 0; i < 3; i++) begin
            cyc('0, 0, 0, 3'd6, 32'h0);
            check("nest_blocked", 32'(b8.int_o), 32'd0);
        end
        cyc('0, 0, 1, 3'd3, 32'h0);
        cyc('0, 0, 0, 3'd5, 32'h0);
        check("nest_isr_clear", last_rd, 32'h0);
        check("nest_int5", 32'(b8.int_o), 32'd1);
        serve(8'h25, "nest_ch5");

        // Rotation: after EOI of channel 0, channel 1 outranks channel 0
        setup(32'h0000_2002);
        cyc(8'h01, 0, 0, 3'd6, 32'h0);
        wait_int('0, "rot_int0");
        serve(8'h20, "rot_ch0");
        cyc('0, 0, 1, 3'd3, 32'h0000_0100);
        cyc(8'h03, 0, 0, 3'd6, 32'h0);
        wait_int('0, "rot_int1");
        serve(8'h21, "rot_first");
        cyc('0, 0, 1, 3'd3, 32'h0);
        wait_int('0, "rot_int0b");
        serve(8'h20, "rot_second");

        // Level request withdrawn while requesting, then spurious inta
        setup(32'h0000_2000);
        cyc('0, 0, 1, 3'd1, 32'h0);
        wait_int(8'h10, "lvl_int");
        cyc('0, 0, 0, 3'd6, 32'h0);
        cyc('0, 0, 0, 3'd6, 32'h0);
        check("lvl_int_fall", 32'(b8.int_o), 32'd0);
        cyc('0, 1, 0, 3'd6, 32'h0);
        check("spurious_valid", 32'(b8.vec_valid), 32'd1);
        check("spurious_vec", 32'(b8.vec), 32'h27);

        // Reset during the second acknowledge pulse
        setup(32'h0000_2000);
        cyc(8'h02, 0, 0, 3'd6, 32'h0);
        wait_int('0, "rst_int1");
        serve(8'h21, "rst_ch1");
        cyc(8'h01, 0, 0, 3'd6, 32'h0);
        wait_int('0, "rst_int0");
        cyc('0, 1, 0, 3'd6, 32'h0);
        b8.inta = 1; reset = 1;
        @(posedge clk); #1;
        check("rst_vec_valid", 32'(b8.vec_valid), 32'd0);
        check("rst_vec", 32'(b8.vec), 32'd0);
        check("rst_int_o", 32'(b8.int_o), 32'd0);
        reset = 0; b8.inta = 0;
        model_reset();
        cyc('0, 0, 0, 3'd0, 32'h0);
        check("rst_mask", last_rd, 32'hFF);
        cyc('0, 0, 0, 3'd5, 32'h0);
        check("rst_isr", last_rd, 32'h0);
        cyc('0, 0, 0, 3'd6, 32'h0);
        check("rst_status", last_rd, 32'h0);
        cyc('0, 0, 0, 3'd2, 32'h0);
        check("rst_ctrl", last_rd, 32'h0);

        // 32-channel instance: auto-EOI on the top channel
        do_reset();
        c32('0, 0, 1, 3'd0, 32'h0);
        c32('0, 0, 1, 3'd2, 32'h0000_4001);
        c32(32'h8000_0000, 0, 0, 3'd6, 32'h0);
        c32('0, 0, 0, 3'd6, 32'h0);
        check("n32_int", 32'(b32.int_o), 32'd1);
        c32('0, 1, 0, 3'd6, 32'h0);
        c32('0, 1, 0, 3'd6, 32'h0);
        check("n32_valid", 32'(b32.vec_valid), 32'd1);
        check("n32_vec", 32'(b32.vec), 32'h5F);
        b32.inta = 0; b32.addr = 3'd5; #1;
        check("n32_isr", b32.rdata, 32'h0);
        $display("[TB] 32-channel auto-EOI vector 0x%0h", b32.vec);
        @(posedge clk); #1;

        // Randomised traffic against the reference model
        do_reset();
        cyc('0, 0, 1, 3'd0, 32'h0);
        irq_v = '0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 7) == 0) irq_v = irq_v ^ (8'($urandom) & 8'($urandom));
            inta_v = ($urandom_range(0, 3) == 0);
            r = $urandom_range(0, 63);
            wr_v = 1'b1;
            wd = 32'h0;
            a = 3'($urandom_range(0, 7));
            if (r < 6) begin
                a = 3'd3;
                wd = (32'($urandom_range(0, 1)) << 8) | 32'($urandom_range(0, 15));
            end else if (r == 6) begin
                a = 3'd0; wd = $urandom & $urandom & $urandom;
            end else if (r == 7) begin
                a = 3'd1; wd = $urandom;
            end else if (r == 8) begin
                a = 3'd2; wd = $urandom & 32'h0000_FF03;
            end else begin
                wr_v = 1'b0;
            end
            cyc(irq_v, inta_v, wr_v, a, wd);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
